// File: rtl/snoopy_command_bus.sv
// rtl/snoopy_command_bus.sv - snoopy command broadcast endpoint with per-cache ack collection
// Optional wait-state timeout enabled by defining SNOOPY_BUS_TIMEOUT_EN.
module snoopy_command_bus #(
  parameter int NUMBER_OF_CACHES   = 4,
  parameter int CACHE_NUMBER_WIDTH = $clog2(NUMBER_OF_CACHES),
  parameter int COMMAND_WIDTH      = 2,
  parameter int TIMEOUT_CYCLES     = 64
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [COMMAND_WIDTH-1:0]      snoopyCommandOut,
  input  logic [CACHE_NUMBER_WIDTH-1:0] cacheNumberOut,
  output logic [COMMAND_WIDTH-1:0]      snoopyCommandIn,
  output logic [NUMBER_OF_CACHES-1:0]   snoopValid,
  input  logic [NUMBER_OF_CACHES-1:0]   snoopAck,
  output logic                          isInvalidated,
  output logic                          busy,
  output logic                          timeoutError
);

  localparam logic [COMMAND_WIDTH-1:0] CMD_NONE = '0;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_BROADCAST = 2'd1,
    S_WAIT      = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  state_t                        state_q, state_d;
  logic [COMMAND_WIDTH-1:0]      cmd_q, cmd_d;
  logic [NUMBER_OF_CACHES-1:0]   pending_q, pending_d;
  logic [NUMBER_OF_CACHES-1:0]   req_mask;
  logic [NUMBER_OF_CACHES-1:0]   pending_acked;
  logic                          timeout_hit;

  logic [COMMAND_WIDTH-1:0]      snoop_cmd_q, snoop_cmd_d;
  logic [NUMBER_OF_CACHES-1:0]   snoop_valid_q, snoop_valid_d;
  logic                          is_inv_q, is_inv_d;
  logic                          busy_q, busy_d;

  // Everyone but the requester; an out-of-range requester snoops all caches.
  always_comb begin
    req_mask = '1;
    if (int'(cacheNumberOut) < NUMBER_OF_CACHES) begin
      req_mask[cacheNumberOut] = 1'b0;
    end
  end

  assign pending_acked = pending_q & ~snoopAck;

`ifdef SNOOPY_BUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LIMIT = TW'(TIMEOUT_CYCLES);

  logic [TW-1:0] wait_cnt_q, wait_cnt_d;
  logic          timeout_err_q, timeout_err_d;

  // Held at zero outside WAIT so every WAIT entry starts a fresh count.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q != S_WAIT) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != T_LIMIT) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  assign timeout_hit   = (state_q == S_WAIT) && (wait_cnt_d == T_LIMIT) && (pending_acked != '0);
  assign timeout_err_d = timeout_err_q | timeout_hit;
  assign timeoutError  = timeout_err_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end
`else
  assign timeout_hit  = 1'b0;
  assign timeoutError = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      cmd_q         <= CMD_NONE;
      pending_q     <= '0;
      snoop_cmd_q   <= CMD_NONE;
      snoop_valid_q <= '0;
      is_inv_q      <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      pending_q     <= pending_d;
      snoop_cmd_q   <= snoop_cmd_d;
      snoop_valid_q <= snoop_valid_d;
      is_inv_q      <= is_inv_d;
      busy_q        <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    pending_d = pending_q;
    case (state_q)
      S_IDLE: begin
        if (snoopyCommandOut != CMD_NONE) begin
          state_d   = S_BROADCAST;
          cmd_d     = snoopyCommandOut;
          pending_d = req_mask;
        end
      end
      S_BROADCAST: begin
        state_d = (pending_q == '0) ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        pending_d = pending_acked;
        if ((pending_acked == '0) || timeout_hit) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (snoopyCommandOut == CMD_NONE) begin
          state_d   = S_IDLE;
          cmd_d     = CMD_NONE;
          pending_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register together with it.
  always_comb begin
    snoop_cmd_d   = CMD_NONE;
    snoop_valid_d = '0;
    is_inv_d      = 1'b0;
    busy_d        = (state_d != S_IDLE);
    case (state_d)
      S_BROADCAST, S_WAIT: begin
        snoop_cmd_d   = cmd_d;
        snoop_valid_d = pending_d;
      end
      S_DONE:  is_inv_d = 1'b1;
      default: ;
    endcase
  end

  assign snoopyCommandIn = snoop_cmd_q;
  assign snoopValid      = snoop_valid_q;
  assign isInvalidated   = is_inv_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_snoopy_command_bus.sv
// tb/tb_snoopy_command_bus.sv - directed and randomized bench for snoopy_command_bus
// Timeout scenario is exercised when SNOOPY_BUS_TIMEOUT_EN is defined.
module tb_snoopy_command_bus;

  localparam int N   = 4;
  localparam int TMO = 8;
`ifdef SNOOPY_BUS_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] snoopyCommandOut;
  logic [1:0] cacheNumberOut;
  logic [1:0] snoopyCommandIn;
  logic [3:0] snoopValid;
  logic [3:0] snoopAck;
  logic       isInvalidated;
  logic       busy;
  logic       timeoutError;

  int checks   = 0;
  int failures = 0;

  logic [3:0] exp_pend;
  logic [1:0] exp_cmd;
  logic       exp_done;
  logic       exp_terr;
  int         wcnt;

  snoopy_command_bus #(
    .NUMBER_OF_CACHES(N),
    .CACHE_NUMBER_WIDTH(2),
    .COMMAND_WIDTH(2),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .snoopyCommandOut(snoopyCommandOut),
    .cacheNumberOut(cacheNumberOut),
    .snoopyCommandIn(snoopyCommandIn),
    .snoopValid(snoopValid),
    .snoopAck(snoopAck),
    .isInvalidated(isInvalidated),
    .busy(busy),
    .timeoutError(timeoutError)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  function automatic logic [1:0] rand_cmd();
    return 2'($urandom_range(1, 3));
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_inv"}, isInvalidated, 0);
    check({tag, "_valid"}, snoopValid, 0);
    check({tag, "_cmd"}, snoopyCommandIn, 0);
    check({tag, "_terr"}, timeoutError, exp_terr);
  endtask

  task automatic check_done(input string tag);
    check({tag, "_inv"}, isInvalidated, 1);
    check({tag, "_valid"}, snoopValid, 0);
    check({tag, "_cmd"}, snoopyCommandIn, 0);
    check({tag, "_busy"}, busy, 1);
    check({tag, "_terr"}, timeoutError, exp_terr);
  endtask

  // Issue a request and step through the BROADCAST cycle into the first WAIT cycle.
  task automatic start_req(input logic [1:0] cmd, input logic [1:0] req);
    snoopyCommandOut = cmd;
    cacheNumberOut   = req;
    snoopAck         = '0;
    exp_cmd          = cmd;
    exp_pend         = 4'hF & ~(4'b0001 << req);
    exp_done         = 1'b0;
    wcnt             = 0;
    tick();
    check("bc_valid", snoopValid, exp_pend);
    check("bc_cmd", snoopyCommandIn, exp_cmd);
    check("bc_busy", busy, 1);
    check("bc_inv", isInvalidated, 0);
    cacheNumberOut   = 2'($urandom);
    snoopyCommandOut = rand_cmd();
    tick();
    check("w0_valid", snoopValid, exp_pend);
    check("w0_cmd", snoopyCommandIn, exp_cmd);
    check("w0_inv", isInvalidated, 0);
  endtask

  task automatic wait_cycle(input logic [3:0] ack);
    snoopAck = ack;
    wcnt++;
    if (TMO_EN && (wcnt >= TMO) && ((exp_pend & ~ack) != 0)) exp_terr = 1'b1;
    exp_done = ((exp_pend & ~ack) == 0) || (TMO_EN && (wcnt >= TMO));
    if (!exp_done) exp_pend = exp_pend & ~ack;
    tick();
    snoopAck = '0;
    if (exp_done) begin
      check_done("done");
    end else begin
      check("wait_valid", snoopValid, exp_pend);
      check("wait_cmd", snoopyCommandIn, exp_cmd);
      check("wait_inv", isInvalidated, 0);
      check("wait_terr", timeoutError, exp_terr);
    end
  endtask

  task automatic finish_txn(input int hold);
    for (int i = 0; i < hold; i++) begin
      snoopyCommandOut = rand_cmd();
      cacheNumberOut   = 2'($urandom);
      tick();
      check_done("hold");
    end
    snoopyCommandOut = 2'd0;
    tick();
    check_idle("idle");
  endtask

  task automatic random_txn();
    start_req(rand_cmd(), 2'($urandom));
    for (int c = 0; c < 40 && !exp_done; c++) begin
      wait_cycle(c >= 30 ? 4'hF : 4'($urandom));
    end
    check("rand_done", isInvalidated, 1);
    finish_txn($urandom_range(0, 3));
  endtask

  initial begin
    reset            = 1'b0;
    snoopyCommandOut = 2'd0;
    cacheNumberOut   = 2'd0;
    snoopAck         = 4'd0;
    exp_pend         = '0;
    exp_cmd          = '0;
    exp_done         = 1'b0;
    exp_terr         = 1'b0;
    wcnt             = 0;
    #3;
    check_idle("reset");
    tick();
    tick();
    reset = 1'b1;
    tick();
    check_idle("post_reset");

    // requester 1 BUS_INVALIDATE, all acks in first WAIT cycle: done at third edge
    start_req(2'd2, 2'd1);
    check("t1_mask", snoopValid, 4'b1101);
    wait_cycle(4'b1101);
    check("t1_latency", isInvalidated, 1);
    finish_txn(0);

    // requester 2 BUS_READ, staggered acks
    start_req(2'd1, 2'd2);
    wait_cycle(4'b0001);
    check("t2_step1", snoopValid, 4'b1010);
    wait_cycle(4'b0000);
    wait_cycle(4'b1000);
    check("t2_step2", snoopValid, 4'b0010);
    wait_cycle(4'b0000);
    wait_cycle(4'b0000);
    wait_cycle(4'b0010);
    check("t2_done", isInvalidated, 1);
    finish_txn(1);

    // requester-bit and duplicate acks are ignored
    start_req(2'd3, 2'd2);
    wait_cycle(4'b0101);
    wait_cycle(4'b0101);
    check("t3_not_done", isInvalidated, 0);
    wait_cycle(4'b0010);
    wait_cycle(4'b1000);
    check("t3_done", isInvalidated, 1);

    // hold request in DONE, then back-to-back request after IDLE
    finish_txn(5);
    start_req(2'd1, 2'd0);
    check("t4_new_mask", snoopValid, 4'b1110);
    wait_cycle(4'b1110);
    finish_txn(0);

    // asynchronous reset in the middle of WAIT
    start_req(2'd2, 2'd3);
    wait_cycle(4'b0001);
    #1 reset = 1'b0;
    #1;
    exp_terr = 1'b0;
    check_idle("async_rst");
    snoopyCommandOut = 2'd0;
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      snoopAck = 4'($urandom);
      tick();
      check_idle("after_rst");
    end
    snoopAck = '0;

`ifdef SNOOPY_BUS_TIMEOUT_EN
    // bit 3 never acks: forced completion after TMO WAIT cycles, sticky error
    start_req(2'd2, 2'd0);
    wait_cycle(4'b0110);
    for (int i = 1; i < TMO; i++) wait_cycle(4'b0000);
    check("tmo_done", isInvalidated, 1);
    check("tmo_err", timeoutError, 1);
    finish_txn(1);
    start_req(2'd1, 2'd1);
    wait_cycle(4'b1101);
    check("tmo_sticky", timeoutError, 1);
    finish_txn(0);
`else
    // without the timeout, WAIT persists indefinitely
    start_req(2'd3, 2'd3);
    for (int i = 0; i < 20; i++) wait_cycle(4'b0000);
    check("persist_inv", isInvalidated, 0);
    check("persist_terr", timeoutError, 0);
    wait_cycle(4'b0111);
    finish_txn(0);
`endif

    for (int t = 0; t < 30; t++) random_txn();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/snoopy_command_bus.md
Name: snoopy_command_bus

Overview:
- Bus-side endpoint of the snoopy command channel in the invalidate-protocol snoopy cache.
- Accepts one coherence command at a time from the granted cache controller and broadcasts it to every other cache's snoop port.
- Collects per-cache snoop acknowledgements, then signals completion back to the requester on isInvalidated.
- Sits between the bus arbiter's granted-controller mux and the N snooping controllers.

Parameters:
- NUMBER_OF_CACHES, 4, number of caches on the bus.
- CACHE_NUMBER_WIDTH, $clog2(NUMBER_OF_CACHES), width of cache index.
- COMMAND_WIDTH, 2, width of Command encoding: 0=NONE, 1=BUS_READ, 2=BUS_INVALIDATE, 3=BUS_READ_EXCLUSIVE.
- TIMEOUT_CYCLES, 64, wait-state cycle limit; used only with SNOOPY_BUS_TIMEOUT_EN.

Ports:
- clock  input  1  single clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- snoopyCommandOut  input  COMMAND_WIDTH  command from granted controller; NONE = no request.
- cacheNumberOut  input  CACHE_NUMBER_WIDTH  index of requesting cache.
- snoopyCommandIn  output  COMMAND_WIDTH  broadcast command to snoopers.
- snoopValid  output  NUMBER_OF_CACHES  per-cache snoop strobe (target mask).
- snoopAck  input  NUMBER_OF_CACHES  per-cache snoop-complete, 1-cycle pulse or level.
- isInvalidated  output  1  transaction complete, to requester.
- busy  output  1  high in any non-IDLE state.
- timeoutError  output  1  sticky error (macro only; tied 0 otherwise).

Behaviour:
- Reset (async, reset=0):
  - State=IDLE.
  - snoopyCommandIn=NONE, snoopValid=0, isInvalidated=0, busy=0, timeoutError=0.
  - Latched command/number and pending mask cleared.
- All outputs are registered.
- FSM states: IDLE, BROADCAST, WAIT, DONE.
- IDLE:
  - If snoopyCommandOut!=NONE: latch command and cacheNumberOut; go to BROADCAST next edge.
  - Otherwise stay in IDLE.
- BROADCAST (exactly 1 cycle):
  - snoopyCommandIn=latched command.
  - snoopValid = pending = all-ones with requester bit cleared.
  - If cacheNumberOut>=NUMBER_OF_CACHES, mask = all-ones.
  - Next state WAIT; if the mask is 0 (NUMBER_OF_CACHES=1), go directly to DONE.
- WAIT:
  - Hold snoopyCommandIn; snoopValid = current pending mask.
  - Each edge: pending &= ~snoopAck.
  - When (pending & ~snoopAck)==0, go to DONE at that edge; same-cycle acks count.
  - Acks from non-pending or requester bits are ignored.
  - Duplicate acks are harmless.
- DONE:
  - isInvalidated=1; snoopValid=0; snoopyCommandIn=NONE.
  - Hold until snoopyCommandOut==NONE (4-phase handshake), then go to IDLE; isInvalidated drops the same edge.
- Input changes while busy:
  - snoopyCommandOut/cacheNumberOut changes in BROADCAST/WAIT are ignored (latched values used).
  - A non-NONE command in DONE is not accepted until IDLE has been passed through.
- Latency, no stalls: request seen at edge 0 → BROADCAST at edge 1 → WAIT at edge 2 → DONE (isInvalidated=1) one edge after the last ack is sampled.
- Minimum request-to-isInvalidated latency: 3 cycles (acks present in first WAIT cycle).
- Reset mid-operation: immediate return to IDLE with all outputs at reset values; the pending transaction is discarded and not resumed.

Optional Feature:
- Macro: SNOOPY_BUS_TIMEOUT_EN.
- Defined:
  - Counter cleared on entering WAIT, increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES with pending!=0, force DONE and set timeoutError=1.
  - timeoutError is sticky until reset.
  - Counter width $clog2(TIMEOUT_CYCLES+1); saturates, never wraps.
- Not defined: no counter; WAIT persists indefinitely; timeoutError tied 0.

Test Plan:
- N=4, requester 1, BUS_INVALIDATE, acks 0,2,3 all in first WAIT cycle → snoopValid=4'b1101 in BROADCAST; isInvalidated=1 at 3rd edge after request.
- Requester 2, BUS_READ, acks staggered: bit0 at WAIT+0, bit3 at WAIT+2, bit1 at WAIT+5 → pending steps 1011→1010→0010→0000; isInvalidated one edge after bit1 ack.
- Ack on requester bit 2 and a duplicate ack on bit 0 → ignored; completion only after bits 1 and 3 ack.
- In DONE, hold snoopyCommandOut=BUS_READ for 5 cycles → isInvalidated stays 1, no new BROADCAST; drop to NONE → IDLE next edge; new request accepted the cycle after.
- Assert reset=0 asynchronously mid-WAIT → outputs go to reset values immediately, without waiting for a clock edge; after release, state is IDLE and no completion is issued.
- With SNOOPY_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=8, bit 3 never acks → DONE after 8 WAIT cycles; timeoutError=1 and stays 1 through later transactions.
